// File: rtl/image_scan_controller_if.sv
// Pixel stream bundle for the scan controller: input valid/ready with pixel, output
// valid/ready with pixel, coordinates and frame markers.
`default_nettype none

interface image_scan_controller_if #(
  parameter int DATA_W = 16,
  parameter int X_W    = 4,
  parameter int Y_W    = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic [X_W-1:0]    x_out;
  logic [Y_W-1:0]    y_out;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, x_out, y_out, sof, eol, eof
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, x_out, y_out, sof, eol, eof
  );
endinterface

`default_nettype wire

// File: rtl/image_scan_controller.sv
// Raster/serpentine scan controller: tags each accepted pixel with (x, y) and
// sof/eol/eof, and presents it through a single registered output stage.
`default_nettype none

module image_scan_controller #(
  parameter int H_PIXELS = 16,
  parameter int V_LINES  = 16,
  parameter int DATA_W   = 16,
  parameter int X_W      = $clog2(H_PIXELS),
  parameter int Y_W      = $clog2(V_LINES)
) (
  input  wire logic clk,
  input  wire logic nrst,
  input  wire logic start,
  input  wire logic clear,
  input  wire logic mode,
  output logic      busy,
  output logic      done,
  image_scan_controller_if.slave pix
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_LINES - 1);

  state_t         state;
  state_t         state_nxt;
  logic [X_W-1:0] x;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y;
  logic [Y_W-1:0] y_nxt;
  logic           mode_q;
  logic           out_valid_q;
  logic           accept;
  logic           launch;
  logic           odd_line;
  logic           line_end;
  logic           frame_end;

  assign pix.in_ready  = (state == SCAN) & (~out_valid_q | pix.out_ready);
  assign pix.out_valid = out_valid_q;
  assign accept        = pix.in_valid & pix.in_ready;
  // A new frame may only begin once any previous frame's last pixel has drained.
  assign launch        = start & ((state == IDLE) | ((state == DONE) & ~out_valid_q));
  assign odd_line      = mode_q & y[0];
  assign line_end      = odd_line ? (x == '0) : (x == X_LAST);
  assign frame_end     = line_end & (y == Y_LAST);
  assign busy          = (state == SCAN);
  assign done          = (state == DONE) & ~out_valid_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (launch) state_nxt = SCAN;
        SCAN:    if (accept && frame_end) state_nxt = DONE;
        DONE:    if (launch) state_nxt = SCAN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Serpentine keeps x at a line end so the next line starts in the same column.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (line_end) begin
      y_nxt = y + Y_W'(1);
      x_nxt = mode_q ? x : '0;
    end else if (odd_line) begin
      x_nxt = x - X_W'(1);
    end else begin
      x_nxt = x + X_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x      <= '0;
      y      <= '0;
      mode_q <= 1'b0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (launch) begin
      x      <= '0;
      y      <= '0;
      mode_q <= mode;
    end else if (accept) begin
      if (frame_end) begin
        x <= '0;
        y <= '0;
      end else begin
        x <= x_nxt;
        y <= y_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid_q  <= 1'b0;
      pix.data_out <= '0;
      pix.x_out    <= '0;
      pix.y_out    <= '0;
      pix.sof      <= 1'b0;
      pix.eol      <= 1'b0;
      pix.eof      <= 1'b0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      pix.data_out <= pix.data_in;
      pix.x_out    <= x;
      pix.y_out    <= y;
      pix.sof      <= (x == '0) & (y == '0);
      pix.eol      <= line_end;
      pix.eof      <= frame_end;
    end else if (pix.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_image_scan_controller.sv
// Directed bench: 4x3 instance for raster/serpentine/backpressure/clear/reset,
// 5x3 instance for random handshakes on a non-power-of-two frame.
`default_nettype none
`timescale 1ns/1ps

module tb_image_scan_controller;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_start = 0, a_clear = 0, a_mode = 0, a_busy, a_done;
  logic b_start = 0, b_clear = 0, b_mode = 0, b_busy, b_done;

  image_scan_controller_if #(.DATA_W(16), .X_W(2), .Y_W(2)) ifa ();
  image_scan_controller_if #(.DATA_W(16), .X_W(3), .Y_W(2)) ifb ();

  image_scan_controller #(.H_PIXELS(4), .V_LINES(3), .DATA_W(16)) dut_a (
    .clk(clk), .nrst(nrst), .start(a_start), .clear(a_clear), .mode(a_mode),
    .busy(a_busy), .done(a_done), .pix(ifa.slave)
  );

  image_scan_controller #(.H_PIXELS(5), .V_LINES(3), .DATA_W(16)) dut_b (
    .clk(clk), .nrst(nrst), .start(b_start), .clear(b_clear), .mode(b_mode),
    .busy(b_busy), .done(b_done), .pix(ifb.slave)
  );

  typedef struct {int d; int x; int y; int f; int cyc;} beat_t;
  beat_t qa[$];
  beat_t qb[$];
  int a_acc = 0, b_acc = 0;
  int a_base = 0, b_base = 0, qa_base = 0, qb_base = 0;

  // Inputs change only at posedge+1, so the negedge sees the values the next edge will use.
  always @(negedge clk) begin
    beat_t b;
    if (ifa.out_valid && ifa.out_ready) begin
      b.d = int'(ifa.data_out); b.x = int'(ifa.x_out); b.y = int'(ifa.y_out);
      b.f = int'({ifa.sof, ifa.eol, ifa.eof}); b.cyc = cyc;
      qa.push_back(b);
    end
    if (ifb.out_valid && ifb.out_ready) begin
      b.d = int'(ifb.data_out); b.x = int'(ifb.x_out); b.y = int'(ifb.y_out);
      b.f = int'({ifb.sof, ifb.eol, ifb.eof}); b.cyc = cyc;
      qb.push_back(b);
    end
    if (ifa.in_valid && ifa.in_ready) a_acc++;
    if (ifb.in_valid && ifb.in_ready) b_acc++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic m);
    a_mode = m; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_mode = ~m;
    a_base = a_acc; qa_base = qa.size();
  endtask

  task automatic feed_a(input int n, input int budget);
    ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    ifa.data_in = 16'(a_acc - a_base + 1);
    for (int i = 0; i < budget && (a_acc - a_base) < n; i++) begin
      tick();
      ifa.data_in = 16'(a_acc - a_base + 1);
    end
    ifa.in_valid = 1'b0;
    if ((a_acc - a_base) < n) chk("feed_timeout", a_acc - a_base, n);
  endtask

  task automatic check_frame_a(input string tn, input logic ser);
    int sx[12];
    sx = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3};
    chk({tn, "_beats"}, qa.size() - qa_base, 12);
    if (qa.size() - qa_base == 12) begin
      for (int i = 0; i < 12; i++) begin
        beat_t b;
        b = qa[qa_base + i];
        chk($sformatf("%s_d%0d", tn, i), b.d, i + 1);
        chk($sformatf("%s_x%0d", tn, i), b.x, ser ? sx[i] : i % 4);
        chk($sformatf("%s_y%0d", tn, i), b.y, i / 4);
        chk($sformatf("%s_flags%0d", tn, i), b.f,
            ((i == 0) ? 4 : 0) + ((i % 4 == 3) ? 2 : 0) + ((i == 11) ? 1 : 0));
        chk($sformatf("%s_cyc%0d", tn, i), b.cyc - qa[qa_base].cyc, i);
      end
    end
  endtask

  task automatic run_b(input string tn);
    int mx = 0, my = 0;
    logic fin = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_base = b_acc; qb_base = qb.size();
    for (int i = 0; i < 600 && !fin; i++) begin
      ifb.in_valid  = ((b_acc - b_base) < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      ifb.out_ready = 1'($urandom_range(0, 1));
      ifb.data_in   = 16'(b_acc - b_base + 1);
      b_start = (i == 10);
      tick();
      if (i == 10) chk({tn, "_busy_after_start"}, int'(b_busy), 1);
      fin = b_done;
    end
    b_start = 1'b0; ifb.in_valid = 1'b0;
    chk({tn, "_done"}, int'(b_done), 1);
    chk({tn, "_beats"}, qb.size() - qb_base, 15);
    if (qb.size() - qb_base == 15) begin
      for (int i = 0; i < 15; i++) begin
        beat_t b;
        b = qb[qb_base + i];
        if (b.x > mx) mx = b.x;
        if (b.y > my) my = b.y;
        chk($sformatf("%s_d%0d", tn, i), b.d, i + 1);
        chk($sformatf("%s_xy%0d", tn, i), b.y * 8 + b.x, (i / 5) * 8 + i % 5);
        chk($sformatf("%s_flags%0d", tn, i), b.f,
            ((i == 0) ? 4 : 0) + ((i % 5 == 4) ? 2 : 0) + ((i == 14) ? 1 : 0));
      end
      chk({tn, "_xmax"}, mx, 4);
      chk({tn, "_ymax"}, my, 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.in_valid = 0; ifa.out_ready = 0; ifa.data_in = '0;
    ifb.in_valid = 0; ifb.out_ready = 0; ifb.data_in = '0;
    tick(); tick();
    chk("rst_out_valid", int'(ifa.out_valid), 0);
    chk("rst_data_out", int'(ifa.data_out), 0);
    chk("rst_busy_done", int'({a_busy, a_done}), 0);
    chk("rst_flags", int'({ifa.sof, ifa.eol, ifa.eof}), 0);
    nrst = 1'b1;
    tick();

    // Raster frame at full throughput.
    start_a(1'b0);
    chk("t1_busy", int'(a_busy), 1);
    chk("t1_in_ready", int'(ifa.in_ready), 1);
    feed_a(12, 40);
    chk("t1_in_ready_drop", int'(ifa.in_ready), 0);
    chk("t1_busy_drop", int'(a_busy), 0);
    chk("t1_done_before_drain", int'(a_done), 0);
    tick();
    chk("t1_done", int'(a_done), 1);
    chk("t1_out_valid", int'(ifa.out_valid), 0);
    check_frame_a("t1", 1'b0);

    // Serpentine frame, launched from DONE.
    start_a(1'b1);
    chk("t2_busy", int'(a_busy), 1);
    feed_a(12, 40);
    tick();
    chk("t2_done", int'(a_done), 1);
    check_frame_a("t2", 1'b1);

    // Backpressure: single pixel held while out_ready is low.
    start_a(1'b0);
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.data_in = 16'd1;
    tick();
    chk("t3_out_valid", int'(ifa.out_valid), 1);
    chk("t3_in_ready_low", int'(ifa.in_ready), 0);
    tick(); tick();
    chk("t3_hold_data", int'(ifa.data_out), 1);
    chk("t3_hold_xy", int'({ifa.x_out, ifa.y_out}), 0);
    chk("t3_accepts", a_acc - a_base, 1);
    ifa.out_ready = 1'b1; ifa.data_in = 16'd2;
    #1;
    chk("t3_in_ready_high", int'(ifa.in_ready), 1);
    tick();
    ifa.out_ready = 1'b0;
    chk("t3_transfer_cnt", qa.size() - qa_base, 1);
    if (qa.size() > qa_base) chk("t3_transfer_d", qa[qa_base].d, 1);
    chk("t3_new_data", int'(ifa.data_out), 2);
    chk("t3_new_x", int'(ifa.x_out), 1);
    chk("t3_new_valid", int'(ifa.out_valid), 1);

    // Clear after five accepts.
    feed_a(5, 20);
    ifa.out_ready = 1'b0;
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("t4_busy", int'(a_busy), 0);
    chk("t4_out_valid", int'(ifa.out_valid), 0);
    chk("t4_done", int'(a_done), 0);
    chk("t4_in_ready", int'(ifa.in_ready), 0);
    chk("t4_beats", qa.size() - qa_base, 4);
    if (qa.size() - qa_base == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("t4_d%0d", i), qa[qa_base + i].d, i + 1);
    start_a(1'b0);
    ifa.in_valid = 1'b1; ifa.out_ready = 1'b1; ifa.data_in = 16'd1;
    tick();
    chk("t4_sof", int'(ifa.sof), 1);
    chk("t4_xy", int'({ifa.x_out, ifa.y_out}), 0);
    chk("t4_data", int'(ifa.data_out), 1);

    // Asynchronous reset between edges.
    #2;
    nrst = 1'b0;
    #1;
    chk("t5_out_valid", int'(ifa.out_valid), 0);
    chk("t5_data_out", int'(ifa.data_out), 0);
    chk("t5_sof", int'(ifa.sof), 0);
    chk("t5_busy", int'(a_busy), 0);
    chk("t5_in_ready", int'(ifa.in_ready), 0);
    a_start = 1'b1;
    tick(); tick();
    chk("t5_start_blocked", int'(a_busy), 0);
    a_start = 1'b0;
    #2;
    nrst = 1'b1;
    tick();
    chk("t5_idle_after", int'(a_busy), 0);
    ifa.in_valid = 1'b0;

    // Non-power-of-two frame with random handshakes, twice.
    run_b("t6a");
    run_b("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/image_scan_controller.md
Name: image_scan_controller

Overview:
Parametrised, single-clock raster scan controller for frame pixel streams. Accepts pixels over a valid/ready input. Tags each pixel with its (x, y) coordinate and with start-of-frame, end-of-line and end-of-frame flags, then presents it on a registered valid/ready output. Sits between the pixel source (SPI receive path) and downstream image processing. Replaces the fixed 16x16 ripple-clocked counter pair with one clock domain, configurable dimensions and a serpentine scan mode.

Parameters:
H_PIXELS, 16, pixels per line; must be >= 2.
V_LINES, 16, lines per frame; must be >= 2.
DATA_W, 16, pixel data width.
X_W, $clog2(H_PIXELS), x coordinate width (derived).
Y_W, $clog2(V_LINES), y coordinate width (derived).

Ports:
clk  in  1  system clock; all state on rising edge.
nrst  in  1  asynchronous active-low reset.
start  in  1  pulse: begin a frame; sampled in IDLE or DONE only.
clear  in  1  synchronous abort; returns to IDLE.
mode  in  1  0 = raster (x always increments); 1 = serpentine (x decrements on odd lines). Latched on start.
in_valid  in  1  input pixel valid.
in_ready  out  1  input pixel accepted when in_valid & in_ready.
data_in  in  DATA_W  input pixel.
out_valid  out  1  output register holds a pixel.
out_ready  in  1  downstream accepts when out_valid & out_ready.
data_out  out  DATA_W  registered pixel.
x_out  out  X_W  column of data_out.
y_out  out  Y_W  line of data_out.
sof  out  1  data_out is first pixel of frame.
eol  out  1  data_out is last pixel of its line.
eof  out  1  data_out is last pixel of frame.
busy  out  1  state is SCAN.
done  out  1  frame complete and output drained; held until start/clear.

Behaviour:
- Reset (nrst=0, async): state IDLE; x=0, y=0; out_valid=0; data_out=0; x_out=0; y_out=0; sof/eol/eof=0; done=0; latched mode=0.
- Priority each cycle: nrst > clear > start > handshakes.
- clear: state to IDLE; counters to 0; out_valid to 0; done to 0; any held pixel dropped.
- IDLE: in_ready=0. On start, latch mode, set x=0, y=0, go to SCAN.
- SCAN: in_ready = ~out_valid | out_ready. This is a single-stage pipeline with full throughput of 1 pixel/cycle.
  - On accept, load data_out=data_in, x_out=x, y_out=y.
  - sof = (x,y) is the first coordinate of the frame.
  - eol = x at line end.
  - eof = eol & (y == V_LINES-1).
  - Set out_valid=1.
- Output handshake: on out_valid & out_ready with no simultaneous accept, out_valid goes to 0. If both happen in the same cycle, the new pixel replaces the old one and out_valid stays 1.
- Counter advance on accept, raster mode:
  - x increments.
  - At x == H_PIXELS-1, x wraps to 0 and y increments.
- Counter advance on accept, serpentine mode:
  - Even y: x counts 0 up to H_PIXELS-1.
  - Odd y: x counts H_PIXELS-1 down to 0.
  - Line end is H_PIXELS-1 on even lines and 0 on odd lines.
  - At line end, y increments and x holds its value. The next line starts at the same column, now counting in the opposite direction.
- Last pixel accepted (eof tagged): in_ready drops the next cycle; counters return to x=0, y=0; go to DONE.
- DONE: in_ready=0; busy=0. done=1 once out_valid==0, i.e. after the last pixel is drained. Start while out_valid==1 is ignored. Start with out_valid==0 clears done, latches mode and enters SCAN.
- Start while in SCAN is ignored; mode changes mid-frame are ignored.
- in_valid low stalls the scan with no state change. out_ready low backpressures in_ready as specified above.
- Coordinates never exceed H_PIXELS-1 or V_LINES-1, including for non-power-of-two sizes.

Test Plan:
1. H=4, V=3, mode=0; start, then in_valid=1 and out_ready=1 continuously with data 1..12. Outputs are 12 beats on consecutive cycles. (x,y) runs (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2). sof on beat 1 only; eol on beats 4, 8, 12; eof on beat 12. done=1 the cycle after beat 12 drains.
2. Same frame with mode=1. The x sequence is 0,1,2,3,3,2,1,0,0,1,2,3. eol is on x=3, x=0, x=3 respectively. eof is on beat 12 at (3,2).
3. out_ready held low after the first accept. in_ready=0 while out_valid=1, and data_out stays 1 at (0,0). Raising out_ready for 1 cycle transfers pixel 1 and accepts pixel 2 in that same cycle, with no loss or duplication.
4. Assert clear mid-frame after 5 accepts. Next cycle: IDLE, out_valid=0, busy=0, done=0. A new start gives sof at (0,0).
5. Assert nrst low asynchronously mid-beat, between clock edges. All outputs reach their reset values immediately, and no start is accepted until nrst is high again.
6. H=5, V=3 (non-power-of-two) with random in_valid/out_ready. Exactly 15 beats, with x never reaching 5 and y never reaching 3. Start in SCAN is ignored. A second frame starts from DONE.
